// File: rtl/bias_loader_pkg.sv
// Shared constants and state encoding for the bias store write-side feeder.
package bias_loader_pkg;

  localparam int BIAS_LANES  = 4;
  localparam int BIAS_GROUP  = 8;
  localparam int GROUP_WORDS = BIAS_GROUP / BIAS_LANES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    PAD   = 3'd3,
    DONE  = 3'd4
  } bias_ld_state_t;

endpackage

// File: rtl/bias_lane_packer.sv
// Packs 32-bit biases into 128-bit words, lane 0 in the low bits; flush emits
// whatever is held with empty lanes zeroed (an all-zero word when nothing is held).
module bias_lane_packer
  import bias_loader_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  input  logic         flush,
  output logic [1:0]   lane,
  output logic         word_valid,
  output logic [127:0] word
);

  // Lane 3 never needs holding: it completes the word and goes straight out.
  logic [95:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      lane       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        hold <= '0;
        lane <= '0;
      end else if (in_valid) begin
        if (lane == 2'(BIAS_LANES - 1)) begin
          word       <= {in_data, hold};
          word_valid <= 1'b1;
          hold       <= '0;
          lane       <= '0;
        end else begin
          case (lane)
            2'd0:    hold[31:0]  <= in_data;
            2'd1:    hold[63:32] <= in_data;
            default: hold[95:64] <= in_data;
          endcase
          lane <= lane + 2'd1;
        end
      end else if (flush) begin
        word       <= {32'b0, hold};
        word_valid <= 1'b1;
        hold       <= '0;
        lane       <= '0;
      end
    end
  end

endmodule

// File: rtl/bias_loader.sv
// Bias store write-side feeder: range-checks the layer bias count, rewinds the
// store pointer, streams packed words in and zero-pads to whole 8-bias groups.
module bias_loader
  import bias_loader_pkg::*;
#(
  parameter int MAX_DEPTH = 256,
  parameter int CNT_WIDTH = $clog2(MAX_DEPTH*4) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_num_bias,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic                 wr_en,
  output logic [127:0]         wr_data,
  output logic                 wr_addr_rst
);

  localparam logic [CNT_WIDTH-1:0] MAX_BIAS = CNT_WIDTH'(MAX_DEPTH * BIAS_LANES);

  bias_ld_state_t       state;
  logic [CNT_WIDTH-1:0] num_bias;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic                 err_sticky;

  logic [1:0]           lane;
  logic                 accept;
  logic                 last_beat;
  logic                 word_fill;
  logic                 finish_load;
  logic                 need_pad;
  logic [CNT_WIDTH-1:0] words_after;

  assign accept      = s_axis_tvalid && s_axis_tready && (state == LOAD);
  assign last_beat   = (beat_cnt == num_bias - CNT_WIDTH'(1));
  assign word_fill   = accept && (lane == 2'(BIAS_LANES - 1));
  assign finish_load = accept && (last_beat || s_axis_tlast);
  assign words_after = word_cnt + CNT_WIDTH'(word_fill);
  // A partial word remains unless this beat landed in the top lane.
  assign need_pad    = (lane != 2'(BIAS_LANES - 1)) ||
                       ((words_after % CNT_WIDTH'(GROUP_WORDS)) != '0);

  bias_lane_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == CLEAR),
    .in_valid   (accept),
    .in_data    (s_axis_tdata),
    .flush      (state == PAD),
    .lane       (lane),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      num_bias      <= '0;
      beat_cnt      <= '0;
      word_cnt      <= '0;
      err_sticky    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      s_axis_tready <= 1'b0;
      wr_addr_rst   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_bias   <= cfg_num_bias;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            busy       <= 1'b1;
            if (cfg_num_bias == '0 || cfg_num_bias > MAX_BIAS) begin
              err_sticky <= 1'b1;
              state      <= DONE;
            end else begin
              err_sticky  <= 1'b0;
              wr_addr_rst <= 1'b1;
              state       <= CLEAR;
            end
          end
        end
        CLEAR: begin
          wr_addr_rst   <= 1'b0;
          s_axis_tready <= 1'b1;
          state         <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            word_cnt <= words_after;
            if (s_axis_tlast != last_beat)
              err_sticky <= 1'b1;
            if (finish_load) begin
              s_axis_tready <= 1'b0;
              state         <= need_pad ? PAD : DONE;
            end
          end
        end
        PAD: begin
          // Each cycle here emits one word; stop once the group is whole.
          word_cnt <= word_cnt + CNT_WIDTH'(1);
          if (((word_cnt + CNT_WIDTH'(1)) % CNT_WIDTH'(GROUP_WORDS)) == '0)
            state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          err   <= err_sticky;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader: table-driven runs, random runs against a
// beat-level reference model, and a mid-load reset sequence.
module tb_bias_loader;

  localparam int MAX_DEPTH = 256;
  localparam int CNT_W     = $clog2(MAX_DEPTH*4) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_num_bias = '0;
  logic             busy, done, err;
  logic [31:0]      s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tready;
  logic             wr_en;
  logic [127:0]     wr_data;
  logic             wr_addr_rst;

  bias_loader #(.MAX_DEPTH(MAX_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_num_bias  (cfg_num_bias),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_addr_rst   (wr_addr_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int n;
    int n_send;
    int tlast_idx;
    bit gaps;
    int exp_words;
    bit exp_err;
  } vec_t;

  logic [31:0]  dat [64];
  logic [127:0] got_q [$];

  // Run observations
  int got_idx, rst_cnt, rst_cyc, rdy_cyc, done_cyc, last_wr_cyc, overlap;
  bit got_done, got_err, rdy_at_done;

  // One complete run: pulse start, drive the stream, record everything seen.
  task automatic run_case(input int n, input int n_send, input int tlast_idx, input bit gaps);
    int cyc;
    got_q.delete();
    got_idx = 0; rst_cnt = 0; rst_cyc = -1; rdy_cyc = -1; done_cyc = -1;
    last_wr_cyc = -1; overlap = 0; got_done = 0; got_err = 0; rdy_at_done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_num_bias = CNT_W'(n);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (got_idx < n_send && (!gaps || $urandom_range(0, 3) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = dat[got_idx];
        s_axis_tlast  = (got_idx == tlast_idx);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      @(negedge clk);
      if (wr_addr_rst) begin rst_cnt++; rst_cyc = cyc; end
      if (s_axis_tready && rdy_cyc < 0) rdy_cyc = cyc;
      if (wr_en) begin got_q.push_back(wr_data); last_wr_cyc = cyc; end
      if (wr_en && wr_addr_rst) overlap++;
      if (s_axis_tvalid && s_axis_tready) got_idx++;
      if (done) begin
        got_done = 1; got_err = err; done_cyc = cyc; rdy_at_done = s_axis_tready;
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Reference: what the store should hold after a run, from the stream rules.
  task automatic check_run(input string tag, input int n, input int n_send,
                           input int tlast_idx, input int tbl_words, input bit tbl_err);
    int acc, nwords;
    bit illegal, exp_err;
    logic [127:0] w;
    illegal = (n == 0) || (n > MAX_DEPTH * 4);
    acc = 0;
    if (!illegal) begin
      for (int k = 0; k < n && k < n_send; k++) begin
        acc = k + 1;
        if (k == tlast_idx) break;
      end
    end
    nwords  = illegal ? 0 : 2 * ((acc + 7) / 8);
    exp_err = illegal || (tlast_idx != n - 1);

    check({tag, " done"}, 128'(got_done), 128'(1));
    check({tag, " err"}, 128'(got_err), 128'(exp_err));
    if (tbl_words >= 0) begin
      check({tag, " err_tbl"}, 128'(got_err), 128'(tbl_err));
      check({tag, " words_tbl"}, 128'(got_q.size()), 128'(tbl_words));
    end
    check({tag, " words"}, 128'(got_q.size()), 128'(nwords));
    check({tag, " accepted"}, 128'(got_idx), 128'(acc));
    check({tag, " addr_rst_cnt"}, 128'(rst_cnt), 128'(illegal ? 0 : 1));
    check({tag, " overlap"}, 128'(overlap), 128'(0));
    check({tag, " tready_at_done"}, 128'(rdy_at_done), 128'(0));
    if (illegal) begin
      check({tag, " done_cyc"}, 128'(done_cyc), 128'(2));
    end else begin
      check({tag, " addr_rst_cyc"}, 128'(rst_cyc), 128'(1));
      check({tag, " tready_cyc"}, 128'(rdy_cyc), 128'(2));
      check({tag, " done_after_wr"}, 128'(done_cyc), 128'(last_wr_cyc + 1));
    end
    for (int wi = 0; wi < nwords && wi < got_q.size(); wi++) begin
      for (int l = 0; l < 4; l++)
        w[32*l +: 32] = (4*wi + l < acc) ? dat[4*wi + l] : 32'h0;
      check($sformatf("%s word%0d", tag, wi), got_q[wi], w);
    end
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{8,    8,    7,  1'b0, 2, 1'b0};
    tbl[1]  = '{5,    5,    4,  1'b0, 2, 1'b0};
    tbl[2]  = '{9,    9,    8,  1'b0, 4, 1'b0};
    tbl[3]  = '{16,   16,   5,  1'b0, 2, 1'b1};
    tbl[4]  = '{0,    0,    -1, 1'b0, 0, 1'b1};
    tbl[5]  = '{1025, 0,    -1, 1'b0, 0, 1'b1};
    tbl[6]  = '{32,   32,   31, 1'b1, 8, 1'b0};
    tbl[7]  = '{4,    6,    3,  1'b0, 2, 1'b0};
    tbl[8]  = '{8,    8,    -1, 1'b0, 2, 1'b1};
    tbl[9]  = '{16,   16,   7,  1'b0, 2, 1'b1};
    tbl[10] = '{1,    1,    0,  1'b0, 2, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset outputs",
          128'({busy, done, err, s_axis_tready, wr_en, wr_addr_rst}), 128'(0));
    check("reset wr_data", wr_data, 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) dat[i] = 32'(i + 1);
    for (int t = 0; t < 11; t++) begin
      run_case(tbl[t].n, tbl[t].n_send, tbl[t].tlast_idx, tbl[t].gaps);
      check_run($sformatf("tbl%0d", t), tbl[t].n, tbl[t].n_send, tbl[t].tlast_idx,
                tbl[t].exp_words, tbl[t].exp_err);
      if (t == 0) begin
        check("n8 word0 literal", got_q.size() > 0 ? got_q[0] : 128'hx,
              128'h00000004_00000003_00000002_00000001);
        check("n8 word1 literal", got_q.size() > 1 ? got_q[1] : 128'hx,
              128'h00000008_00000007_00000006_00000005);
      end
      if (t == 1)
        check("n5 word1 literal", got_q.size() > 1 ? got_q[1] : 128'hx,
              128'h00000000_00000000_00000000_00000005);
    end

    // Random runs against the reference.
    for (int r = 0; r < 8; r++) begin
      int n, ns, tl;
      for (int i = 0; i < 64; i++) dat[i] = $urandom;
      n  = $urandom_range(1, 40);
      ns = n + $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       tl = $urandom_range(0, n - 1);
        1:       tl = -1;
        default: tl = n - 1;
      endcase
      run_case(n, ns, tl, 1'($urandom_range(0, 1)));
      check_run($sformatf("rnd%0d", r), n, ns, tl, -1, 1'b0);
    end

    // Reset in the middle of a load, with err still set from an earlier run.
    run_case(0, 0, -1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_num_bias = CNT_W'(32);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = $urandom | 32'h1;
      s_axis_tlast  = 1'b0;
    end
    @(negedge clk);
    check("pre-reset busy", 128'(busy), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun reset ctrl",
          128'({busy, done, err, s_axis_tready, wr_en, wr_addr_rst}), 128'(0));
    check("midrun reset wr_data", wr_data, 128'(0));
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) dat[i] = 32'h100 + 32'(i);
    run_case(8, 8, 7, 1'b0);
    check_run("post-reset", 8, 8, 7, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
